button_toggle: RTL and testbench

//  Input-side counterpart of the combinational pin inverter: conditions a raw

---
 rtl/button_toggle.sv | 55 +++++
 tb/tb_button_toggle.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/button_toggle.sv
// button_toggle: synchronises and debounces a raw button pin, emits press/release strobes
// and keeps a toggle bit that inverts on every debounced press.
module button_toggle #(
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int SYNC_STAGES     = 2,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  input  logic toggle_clr,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic toggle_q
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, press_q, press_d, release_q, release_d, tog_q, tog_d;
  logic pressed, differ, done;
  // Polarity is normalised after the chain so the chain resets to the idle pin level.
  always_comb begin
    pressed   = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;
    differ    = pressed != level_q;
    done      = differ && (cnt_q == LAST);
    cnt_d     = (!differ || done) ? '0 : cnt_q + 1'b1;
    level_d   = done ? pressed : level_q;
    press_d   = done && pressed;
    release_d = done && !pressed;
    tog_d     = toggle_clr ? 1'b0 : (press_d ? ~tog_q : tog_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= {SYNC_STAGES{ACTIVE_LOW}};
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      tog_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_in};
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      tog_q     <= tog_d;
    end
  end
  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign toggle_q      = tog_q;
endmodule

// File: tb/tb_button_toggle.sv
// tb_button_toggle: directed scenarios plus random pin activity, checked against
// a window-based reference model of the debounced button.
module tb_button_toggle;
  localparam int D = 4;
  localparam int S = 2;
  localparam bit AL = 1'b1;
  logic clk, rst_n, btn_in, toggle_clr;
  logic btn_level, press_pulse, release_pulse, toggle_q;
  int checks = 0;
  int errors = 0;
  int npress = 0;
  bit hist[$];
  bit seen[$];
  bit m_lvl, m_pp, m_rp, m_tg;

  button_toggle #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S), .ACTIVE_LOW(AL)) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .toggle_clr(toggle_clr),
    .btn_level(btn_level), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .toggle_q(toggle_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    seen.delete();
    for (int i = 0; i < S; i++) hist.push_back(1'b0);
    m_lvl = 0; m_pp = 0; m_rp = 0; m_tg = 0;
  endtask

  // The level flips once the debouncer has seen D consecutive pressed values opposite to it.
  task automatic model_edge();
    bit all_diff;
    hist.push_back(AL ? ~btn_in : btn_in);
    seen.push_back(hist[hist.size() - 1 - S]);
    m_pp = 0; m_rp = 0;
    if (seen.size() >= D) begin
      all_diff = 1;
      for (int i = seen.size() - D; i < seen.size(); i++)
        if (seen[i] == m_lvl) all_diff = 0;
      if (all_diff) begin
        m_lvl = ~m_lvl;
        m_pp = m_lvl;
        m_rp = ~m_lvl;
        seen.delete();
      end
    end
    m_tg = toggle_clr ? 1'b0 : (m_pp ? ~m_tg : m_tg);
    while (hist.size() > S + 1) void'(hist.pop_front());
    while (seen.size() > D) void'(seen.pop_front());
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".level"}, btn_level, m_lvl);
    chk({tag, ".press"}, press_pulse, m_pp);
    chk({tag, ".release"}, release_pulse, m_rp);
    chk({tag, ".toggle"}, toggle_q, m_tg);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    if (press_pulse === 1'b1) npress++;
    check_all(tag);
  endtask

  // Drive a new pin level and verify the pulse lands exactly on edge S+D.
  task automatic edge6(input string tag, input logic pin, input logic clr6);
    btn_in = pin;
    repeat (S + D - 1) begin
      tick(tag);
      chk({tag, ".early_pulse"}, press_pulse | release_pulse, 1'b0);
    end
    toggle_clr = clr6;
    tick(tag);
    toggle_clr = 0;
    chk({tag, ".press_at6"}, press_pulse, ~pin);
    chk({tag, ".release_at6"}, release_pulse, pin);
    chk({tag, ".level_at6"}, btn_level, ~pin);
    repeat (3) tick(tag);
  endtask

  task automatic clear_toggle();
    toggle_clr = 1;
    tick("clr");
    toggle_clr = 0;
    chk("clr.toggle", toggle_q, 1'b0);
  endtask

  initial begin
    int n0;
    clk = 0; rst_n = 0; btn_in = 1; toggle_clr = 0;
    model_reset();
    #2;
    check_all("reset");
    tick("reset_hold");
    #3 rst_n = 1;
    // 1: idle pin, nothing happens
    repeat (20) tick("idle");
    chk("idle.no_press", npress == 0, 1'b1);
    // 2: clean press and release
    edge6("press", 1'b0, 1'b0);
    chk("press.toggle", toggle_q, 1'b1);
    repeat (4) tick("held");
    edge6("release", 1'b1, 1'b0);
    chk("release.toggle", toggle_q, 1'b1);
    // 3: bounce on the way down restarts the count
    clear_toggle();
    n0 = npress;
    btn_in = 0; repeat (3) tick("bounce");
    btn_in = 1; tick("bounce");
    edge6("bounce", 1'b0, 1'b0);
    repeat (6) tick("bounce_hold");
    chk("bounce.one_press", npress == n0 + 1, 1'b1);
    chk("bounce.toggle", toggle_q, 1'b1);
    edge6("bounce_rel", 1'b1, 1'b0);
    // 4: three-cycle glitch never qualifies
    n0 = npress;
    btn_in = 0; repeat (3) tick("glitch");
    btn_in = 1; repeat (10) tick("glitch");
    chk("glitch.no_press", npress == n0, 1'b1);
    chk("glitch.level", btn_level, 1'b0);
    // 5: toggle sequence, then clear colliding with a press
    clear_toggle();
    for (int i = 0; i < 3; i++) begin
      edge6("tog_press", 1'b0, 1'b0);
      chk("tog.value", toggle_q, (i % 2) == 0);
      edge6("tog_rel", 1'b1, 1'b0);
    end
    edge6("clr_press", 1'b0, 1'b1);
    chk("clr_press.toggle", toggle_q, 1'b0);
    edge6("clr_rel", 1'b1, 1'b0);
    // 6: reset in the middle of qualifying a press
    btn_in = 0;
    repeat (4) tick("mid");
    #2 rst_n = 0;
    model_reset();
    #1 check_all("mid_reset");
    repeat (3) tick("in_reset");
    #3 rst_n = 1;
    n0 = npress;
    repeat (S + D - 1) tick("requal");
    chk("requal.early", press_pulse, 1'b0);
    tick("requal");
    chk("requal.press_at6", press_pulse, 1'b1);
    repeat (20) tick("requal_hold");
    chk("requal.one_press", npress == n0 + 1, 1'b1);
    // random pin activity with occasional clears and resets
    repeat (150) begin
      btn_in = 1'($urandom_range(0, 1));
      toggle_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 39) == 0) begin
        #2 rst_n = 0;
        model_reset();
        #1 check_all("rnd_reset");
        tick("rnd_in_reset");
        #3 rst_n = 1;
      end
      repeat ($urandom_range(1, 8)) tick("rnd");
    end
    toggle_clr = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
